memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- RV32I MEM stage plus MEM/WB pipeline register; sits between the EX/MEM register and writeBack.
- Issues loads and stores to an external data-memory port using a req/ack handshake and handles byte-lane alignment and load sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding and delivers registered results (regWrite, memtoReg, rd, operands) to writeBack.

Parameters:
TIMEOUT, 16, max cycles an access may wait for dmem_ack before abort (≥1)
CNT_W, 5, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
memory_in_valid  in  1  instruction present on inputs
memory_in_regWrite  in  1  register write enable
memory_in_memRead  in  1  load
memory_in_memWrite  in  1  store
memory_in_memtoReg  in  3  writeBack result select, passed through
memory_in_aluOut  in  32  effective address / ALU result
memory_in_rs2  in  32  store data
memory_in_rd  in  5  destination register
memory_in_instr  in  32  instruction; funct3 = instr[14:12]
memory_in_immediate  in  32  pass-through
memory_in_imm_plus_pc_or_rs1  in  32  pass-through
memory_in_pc_plus_four  in  32  pass-through
dmem_req  out  1  access request
dmem_we  out  1  1=write
dmem_addr  out  32  word-aligned address (aluOut & ~3)
dmem_wdata  out  32  lane-shifted store data
dmem_wstrb  out  4  byte enables
dmem_ack  in  1  access accepted; rdata valid same cycle for reads
dmem_rdata  in  32  read word
memory_out_stall  out  1  hold EX/MEM and earlier stages
memory_out_regWrite, memory_out_memRead  out  1  registered
memory_out_memtoReg  out  3  registered
memory_out_rd  out  5  registered
memory_out_aluOut, memory_out_dataMemOut, memory_out_immediate, memory_out_imm_plus_pc_or_rs1, memory_out_pc_plus_four, memory_out_instr  out  32  registered
memory_out_misalign  out  1  registered; access not issued, address misaligned
memory_out_bus_err  out  1  registered; access aborted by timeout

Behaviour:
- Reset (async, rst_n=0): all memory_out_* = 0; dmem_req = 0; state = IDLE; counter = 0. A reset during WAIT drops dmem_req immediately with no write completed.
- Access = valid & (memRead | memWrite). Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. A misaligned access is never issued.
- FSM states:
  - IDLE: for an aligned access, dmem_req is driven combinationally from the inputs. If ack arrives the same cycle, the access completes with zero stall. Otherwise stall=1 and the state goes to WAIT with counter=1.
  - WAIT: dmem_req held, address/data stable; counter increments each cycle.
    - On ack: complete; stall=0 that cycle; go to IDLE.
    - If counter==TIMEOUT without ack: abort; stall=0; go to IDLE; bus_err=1 registered.
- Stall: stall = req & ~ack & ~abort. While stall=1 the MEM/WB register loads a bubble (all controls 0, data 0). Upstream holds inputs stable.
- Completion/pass-through: MEM/WB loads on any cycle with stall=0.
  - Non-memory instruction: 1-cycle latency, loaded at the next edge.
  - Invalid input: loads a bubble.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 or 1100; wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111; wdata = rs2.
  - dmem_we=1. Stores never set regWrite.
- Load extraction: select byte/half by addr[1:0], then extend per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. Other funct3 values give dataMemOut=0.
- Misalign or bus_err: registered regWrite forced to 0; the corresponding flag = 1 for that single output cycle; other fields pass through.
- Both memRead and memWrite set is treated as a store.

Decomposition:
- Shared package:
  - funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - memtoReg encodings 000 dmem, 001 imm+pc/rs1, 010 imm, 011 pc+4, 100 alu.
  - FSM state typedef {IDLE, WAIT}.
- One natural combinational sub-module, load_store_align: generates wstrb/wdata and extracts/extends load data.

Test Plan:
- SW addr 0x104, rs2=0xDEADBEEF, ack same cycle -> dmem_addr=0x104, wstrb=1111, stall never asserted, out_regWrite=0.
- LB addr 0x103, rdata=0x80FF_0000, ack after 3 cycles -> stall high 3 cycles, bubbles emitted; then dataMemOut=0xFFFFFF80, regWrite=1.
- LHU addr 0x202, rdata=0x8001_1234 -> dataMemOut=0x00008001; LH same -> 0xFFFF8001.
- LW addr 0x102 -> no dmem_req, misalign=1, regWrite=0, no stall.
- Load with no ack, TIMEOUT=16 -> stall 15 cycles, abort on cycle 16, bus_err=1 one cycle, regWrite=0, state IDLE.
- rst_n low during WAIT -> dmem_req=0 immediately, all outputs 0; a subsequent ADD passes through with 1-cycle latency and aluOut unchanged.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, writeBack select, FSM states.
package memory_stage_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // writeBack result select
    localparam logic [2:0] MTR_DMEM   = 3'b000;
    localparam logic [2:0] MTR_IMMPC  = 3'b001;
    localparam logic [2:0] MTR_IMM    = 3'b010;
    localparam logic [2:0] MTR_PC4    = 3'b011;
    localparam logic [2:0] MTR_ALU    = 3'b100;

    typedef enum logic {IDLE, WAIT} state_t;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic        regWrite;
        logic        memRead;
        logic [2:0]  memtoReg;
        logic [4:0]  rd;
        logic [31:0] aluOut;
        logic [31:0] dataMemOut;
        logic [31:0] immediate;
        logic [31:0] imm_plus_pc_or_rs1;
        logic [31:0] pc_plus_four;
        logic [31:0] instr;
        logic        misalign;
        logic        bus_err;
    } memwb_t;

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Byte-lane steering for stores and byte/half extraction plus extension for loads.
module load_store_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_store_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    // Store lanes: replicate data across the word, strobe picks the lane(s)
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        if (is_store_i) begin
            case (funct3_i)
                F3_SB: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{rs2_i[7:0]}};
                end
                F3_SH: begin
                    wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{rs2_i[15:0]}};
                end
                F3_SW: begin
                    wstrb_o = 4'b1111;
                    wdata_o = rs2_i;
                end
                default: ;
            endcase
        end
    end

    // Load: bring the addressed byte/half to bit 0, then extend
    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        load_data_o = 32'h0;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data_o = rdata_i;
            F3_LBU:  load_data_o = {24'h0, shifted[7:0]};
            F3_LHU:  load_data_o = {16'h0, shifted[15:0]};
            default: load_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: dmem req/ack handshake with timeout, alignment, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_in_valid,
    input  logic        memory_in_regWrite,
    input  logic        memory_in_memRead,
    input  logic        memory_in_memWrite,
    input  logic [2:0]  memory_in_memtoReg,
    input  logic [31:0] memory_in_aluOut,
    input  logic [31:0] memory_in_rs2,
    input  logic [4:0]  memory_in_rd,
    input  logic [31:0] memory_in_instr,
    input  logic [31:0] memory_in_immediate,
    input  logic [31:0] memory_in_imm_plus_pc_or_rs1,
    input  logic [31:0] memory_in_pc_plus_four,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        memory_out_stall,
    output logic        memory_out_regWrite,
    output logic        memory_out_memRead,
    output logic [2:0]  memory_out_memtoReg,
    output logic [4:0]  memory_out_rd,
    output logic [31:0] memory_out_aluOut,
    output logic [31:0] memory_out_dataMemOut,
    output logic [31:0] memory_out_immediate,
    output logic [31:0] memory_out_imm_plus_pc_or_rs1,
    output logic [31:0] memory_out_pc_plus_four,
    output logic [31:0] memory_out_instr,
    output logic        memory_out_misalign,
    output logic        memory_out_bus_err
);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    memwb_t             memwb_q, memwb_d;

    logic [2:0]  funct3;
    logic        access, misalign, req_c, abort, stall;
    logic [31:0] load_data;

    assign funct3   = memory_in_instr[14:12];
    assign access   = memory_in_valid & (memory_in_memRead | memory_in_memWrite);
    assign misalign = access & (((funct3[1:0] == 2'b01) & memory_in_aluOut[0]) |
                                ((funct3[1:0] == 2'b10) & (memory_in_aluOut[1:0] != 2'b00)));
    assign req_c    = access & ~misalign;

    // cnt_d is the number of cycles this access has been waiting, including this one;
    // hitting TIMEOUT without ack aborts in the current cycle
    assign cnt_d    = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign abort    = req_c & ~dmem_ack & (cnt_d == CNT_W'(TIMEOUT));
    assign stall    = req_c & ~dmem_ack & ~abort;

    // Request is gated by rst_n so an in-flight access drops the instant reset asserts
    assign dmem_req         = rst_n & req_c;
    assign dmem_we          = memory_in_memWrite;
    assign dmem_addr        = {memory_in_aluOut[31:2], 2'b00};
    assign memory_out_stall = stall;

    load_store_align u_align (
        .funct3_i    (funct3),
        .addr_lo_i   (memory_in_aluOut[1:0]),
        .is_store_i  (memory_in_memWrite),
        .rs2_i       (memory_in_rs2),
        .rdata_i     (dmem_rdata),
        .wstrb_o     (dmem_wstrb),
        .wdata_o     (dmem_wdata),
        .load_data_o (load_data)
    );

    // Access FSM: enter/stay in WAIT only while the request is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (stall) begin
            state_q <= WAIT;
            cnt_q   <= cnt_d;
        end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end
    end

    // Next MEM/WB contents: bubble on stall or invalid input, else the completed instruction
    always_comb begin
        memwb_d = '0;
        if (memory_in_valid && !stall) begin
            memwb_d.regWrite           = memory_in_regWrite & ~memory_in_memWrite & ~misalign & ~abort;
            memwb_d.memRead            = memory_in_memRead & ~memory_in_memWrite;
            memwb_d.memtoReg           = memory_in_memtoReg;
            memwb_d.rd                 = memory_in_rd;
            memwb_d.aluOut             = memory_in_aluOut;
            memwb_d.dataMemOut         = (req_c & ~memory_in_memWrite & dmem_ack) ? load_data : 32'h0;
            memwb_d.immediate          = memory_in_immediate;
            memwb_d.imm_plus_pc_or_rs1 = memory_in_imm_plus_pc_or_rs1;
            memwb_d.pc_plus_four       = memory_in_pc_plus_four;
            memwb_d.instr              = memory_in_instr;
            memwb_d.misalign           = misalign;
            memwb_d.bus_err            = abort;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) memwb_q <= '0;
        else        memwb_q <= memwb_d;
    end

    assign memory_out_regWrite           = memwb_q.regWrite;
    assign memory_out_memRead            = memwb_q.memRead;
    assign memory_out_memtoReg           = memwb_q.memtoReg;
    assign memory_out_rd                 = memwb_q.rd;
    assign memory_out_aluOut             = memwb_q.aluOut;
    assign memory_out_dataMemOut         = memwb_q.dataMemOut;
    assign memory_out_immediate          = memwb_q.immediate;
    assign memory_out_imm_plus_pc_or_rs1 = memwb_q.imm_plus_pc_or_rs1;
    assign memory_out_pc_plus_four       = memwb_q.pc_plus_four;
    assign memory_out_instr              = memwb_q.instr;
    assign memory_out_misalign           = memwb_q.misalign;
    assign memory_out_bus_err            = memwb_q.bus_err;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage against a behavioural load/store model.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_regWrite, in_memRead, in_memWrite;
    logic [2:0]  in_memtoReg;
    logic [31:0] in_aluOut, in_rs2, in_instr, in_imm, in_ipr, in_pc4;
    logic [4:0]  in_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        o_stall, o_regWrite, o_memRead, o_misalign, o_bus_err;
    logic [2:0]  o_memtoReg;
    logic [4:0]  o_rd;
    logic [31:0] o_aluOut, o_dmo, o_imm, o_ipr, o_pc4, o_instr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .memory_in_valid(in_valid), .memory_in_regWrite(in_regWrite),
        .memory_in_memRead(in_memRead), .memory_in_memWrite(in_memWrite),
        .memory_in_memtoReg(in_memtoReg), .memory_in_aluOut(in_aluOut),
        .memory_in_rs2(in_rs2), .memory_in_rd(in_rd), .memory_in_instr(in_instr),
        .memory_in_immediate(in_imm), .memory_in_imm_plus_pc_or_rs1(in_ipr),
        .memory_in_pc_plus_four(in_pc4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .memory_out_stall(o_stall), .memory_out_regWrite(o_regWrite),
        .memory_out_memRead(o_memRead), .memory_out_memtoReg(o_memtoReg),
        .memory_out_rd(o_rd), .memory_out_aluOut(o_aluOut),
        .memory_out_dataMemOut(o_dmo), .memory_out_immediate(o_imm),
        .memory_out_imm_plus_pc_or_rs1(o_ipr), .memory_out_pc_plus_four(o_pc4),
        .memory_out_instr(o_instr), .memory_out_misalign(o_misalign),
        .memory_out_bus_err(o_bus_err)
    );

    // Reference load result: pick bytes arithmetically from the word, extend by value range
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [31:0] s;
        int v;
        s = w >> (8 * lo);
        case (f3)
            3'd0: begin v = int'(s % 256);   if (v > 127)   v -= 256;   return v; end
            3'd1: begin v = int'(s % 65536); if (v > 32767) v -= 65536; return v; end
            3'd2: return w;
            3'd4: return s % 256;
            3'd5: return s % 65536;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'd0: return 4'(1 << lo);
            3'd1: return 4'(3 << lo);
            3'd2: return 4'hf;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0: return (d & 32'hff) * 32'h01010101;
            3'd1: return (d & 32'hffff) * 32'h00010001;
            3'd2: return d;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                         input logic [2:0] m2r, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd);
        in_valid = v; in_regWrite = rw; in_memRead = mr; in_memWrite = mw;
        in_memtoReg = m2r; in_aluOut = alu; in_rs2 = rs2; in_rd = rd;
        in_instr = {17'h0, f3, rd, mw ? 7'h23 : (mr ? 7'h03 : 7'h33)};
        in_imm = $urandom; in_ipr = $urandom; in_pc4 = $urandom;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0);
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        dmem_rdata = 32'h0;
        #12;
        n_checks++;
        if ({o_regWrite, o_memRead, o_memtoReg, o_rd, o_aluOut, o_dmo, o_imm, o_ipr,
             o_pc4, o_instr, o_misalign, o_bus_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, want all zero");
        end
        n_checks++;
        if ({dmem_req, o_stall} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req: got req/stall=%b want 00", {dmem_req, o_stall});
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_sw_same_cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 32'h104, 32'hDEADBEEF, 5'd7);
        dmem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, dmem_we, o_stall, dmem_addr, dmem_wstrb, dmem_wdata} !==
            {1'b1, 1'b1, 1'b0, 32'h104, 4'hf, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL sw_bus: got req=%b we=%b stall=%b addr=%h strb=%h wd=%h want 1 1 0 104 f deadbeef",
                     dmem_req, dmem_we, o_stall, dmem_addr, dmem_wstrb, dmem_wdata);
        end
        step();
        n_checks++;
        if ({o_regWrite, o_aluOut, o_misalign, o_bus_err} !== {1'b0, 32'h104, 2'b00}) begin
            n_fail++; $display("FAIL sw_out: got rw=%b alu=%h mis=%b be=%b want 0 104 0 0",
                               o_regWrite, o_aluOut, o_misalign, o_bus_err);
        end
        drive_idle();
    endtask

    task automatic test_lb_wait();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 32'h103, 32'h0, 5'd9);
        dmem_ack = 1'b0; dmem_rdata = 32'h80FF_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({o_stall, dmem_req, dmem_addr} !== {2'b11, 32'h100}) begin
                n_fail++; $display("FAIL lb_stall cycle %0d: got stall=%b req=%b addr=%h want 1 1 100",
                                   i, o_stall, dmem_req, dmem_addr);
            end
            step();
            n_checks++;
            if ({o_regWrite, o_rd, o_aluOut} !== '0) begin
                n_fail++; $display("FAIL lb_bubble cycle %0d: got rw=%b rd=%0d alu=%h want 0 0 0",
                                   i, o_regWrite, o_rd, o_aluOut);
            end
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL lb_ack_stall: got %b want 0", o_stall);
        end
        step();
        n_checks++;
        if ({o_dmo, o_regWrite, o_rd} !== {32'hFFFFFF80, 1'b1, 5'd9}) begin
            n_fail++; $display("FAIL lb_result: got dmo=%h rw=%b rd=%0d want ffffff80 1 9",
                               o_dmo, o_regWrite, o_rd);
        end
        drive_idle();
    endtask

    task automatic test_lhu_lh();
        logic [31:0] exp_v [2];
        logic [2:0]  f3s   [2];
        exp_v[0] = 32'h00008001; exp_v[1] = 32'hFFFF8001;
        f3s[0] = 3'd5; f3s[1] = 3'd1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, f3s[k], 32'h202, 32'h0, 5'd3);
            dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
            step();
            n_checks++;
            if (o_dmo !== exp_v[k]) begin
                n_fail++; $display("FAIL lh_case %0d: got %h want %h", k, o_dmo, exp_v[k]);
            end
        end
        drive_idle();
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 32'h102, 32'h0, 5'd4);
        dmem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, o_stall} !== 2'b00) begin
            n_fail++; $display("FAIL mis_lw_req: got req/stall=%b want 00", {dmem_req, o_stall});
        end
        step();
        n_checks++;
        if ({o_misalign, o_regWrite, o_bus_err, o_aluOut, o_rd} !== {3'b100, 32'h102, 5'd4}) begin
            n_fail++; $display("FAIL mis_lw_out: got mis=%b rw=%b be=%b alu=%h rd=%0d want 1 0 0 102 4",
                               o_misalign, o_regWrite, o_bus_err, o_aluOut, o_rd);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 32'h201, 32'h55, 5'd0);
        @(negedge clk);
        n_checks++;
        if ({dmem_req, o_stall} !== 2'b00) begin
            n_fail++; $display("FAIL mis_sh_req: got req/stall=%b want 00", {dmem_req, o_stall});
        end
        step();
        drive_idle();
        step();
        n_checks++;
        if (o_misalign !== 1'b0) begin
            n_fail++; $display("FAIL mis_one_cycle: got %b want 0", o_misalign);
        end
    endtask

    task automatic test_timeout();
        int stalls = 0;
        bit aborted = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 32'h200, 32'h0, 5'd6);
        dmem_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_stall) begin
                stalls++;
                step();
            end else begin
                aborted = dmem_req;
                break;
            end
        end
        n_checks++;
        if (stalls != 15 || !aborted) begin
            n_fail++; $display("FAIL timeout_stalls: got %0d stalls abort=%0d want 15 1", stalls, aborted);
        end
        step();
        n_checks++;
        if ({o_bus_err, o_regWrite, o_misalign, o_aluOut} !== {3'b100, 32'h200}) begin
            n_fail++; $display("FAIL timeout_out: got be=%b rw=%b mis=%b alu=%h want 1 0 0 200",
                               o_bus_err, o_regWrite, o_misalign, o_aluOut);
        end
        drive_idle();
        step();
        n_checks++;
        if (o_bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_one_cycle: got %b want 0", o_bus_err);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 32'h300, 32'h0, 5'd6);
        dmem_ack = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        n_checks++;
        if (o_stall !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: got stall=%b want 0", o_stall);
        end
        step();
        drive_idle();
    endtask

    task automatic test_reset_in_wait();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd2, 32'h400, 32'h0, 5'd8);
        dmem_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_wait_req: got %b want 0", dmem_req);
        end
        n_checks++;
        if ({o_regWrite, o_memRead, o_memtoReg, o_rd, o_aluOut, o_dmo, o_misalign, o_bus_err} !== '0) begin
            n_fail++; $display("FAIL rst_wait_out: got nonzero outputs, want all zero");
        end
        drive_idle();
        step();
        #3 rst_n = 1'b1;
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd0, 32'h0000_1234, 32'h0, 5'd12);
        @(negedge clk);
        n_checks++;
        if ({dmem_req, o_stall} !== 2'b00) begin
            n_fail++; $display("FAIL add_req: got req/stall=%b want 00", {dmem_req, o_stall});
        end
        step();
        n_checks++;
        if ({o_aluOut, o_regWrite, o_memtoReg, o_rd, o_dmo} !== {32'h1234, 1'b1, 3'd4, 5'd12, 32'h0}) begin
            n_fail++; $display("FAIL add_out: got alu=%h rw=%b m2r=%0d rd=%0d dmo=%h want 1234 1 4 12 0",
                               o_aluOut, o_regWrite, o_memtoReg, o_rd, o_dmo);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [2:0]  lds [5];
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] addr, rs2, rd_word, e_imm, e_pc4;
        logic [4:0]  rd;
        bit          st;
        int          d;
        lds[0] = 3'd0; lds[1] = 3'd1; lds[2] = 3'd2; lds[3] = 3'd4; lds[4] = 3'd5;
        for (int t = 0; t < 40; t++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : lds[$urandom_range(0, 4)];
            lo = 2'($urandom_range(0, 3));
            if (f3[1:0] == 2'b01) lo[0] = 1'b0;
            if (f3[1:0] == 2'b10) lo = 2'b00;
            addr = {$urandom() >> 2, lo};
            rs2 = $urandom; rd_word = $urandom; rd = 5'($urandom_range(1, 31));
            d = $urandom_range(0, 3);
            drive(1'b1, 1'b1, ~st, st, 3'd0, f3, addr, rs2, rd);
            e_imm = in_imm; e_pc4 = in_pc4;
            dmem_rdata = rd_word;
            dmem_ack = (d == 0);
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                n_checks++;
                if ({o_stall, dmem_req} !== 2'b11) begin
                    n_fail++; $display("FAIL rnd_stall t=%0d i=%0d: got %b want 11", t, i, {o_stall, dmem_req});
                end
                step();
                if (i == d - 1) dmem_ack = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if ({o_stall, dmem_req, dmem_we, dmem_addr} !== {2'b01, st, addr & 32'hFFFF_FFFC}) begin
                n_fail++; $display("FAIL rnd_bus t=%0d: got stall=%b req=%b we=%b addr=%h want 0 1 %b %h",
                                   t, o_stall, dmem_req, dmem_we, dmem_addr, st, addr & 32'hFFFF_FFFC);
            end
            if (st) begin
                n_checks++;
                if ({dmem_wstrb, dmem_wdata} !== {ref_strb(f3, lo), ref_wdata(f3, rs2)}) begin
                    n_fail++; $display("FAIL rnd_store t=%0d f3=%0d: got strb=%h wd=%h want %h %h", t, f3,
                                       dmem_wstrb, dmem_wdata, ref_strb(f3, lo), ref_wdata(f3, rs2));
                end
            end
            step();
            n_checks++;
            if ({o_regWrite, o_memRead, o_rd, o_aluOut, o_dmo, o_imm, o_pc4} !==
                {~st, ~st, rd, addr, st ? 32'h0 : ref_load(f3, lo, rd_word), e_imm, e_pc4}) begin
                n_fail++; $display("FAIL rnd_out t=%0d f3=%0d st=%0d: got rw=%b dmo=%h rd=%0d want rw=%b dmo=%h rd=%0d",
                                   t, f3, st, o_regWrite, o_dmo, o_rd, ~st,
                                   st ? 32'h0 : ref_load(f3, lo, rd_word), rd);
            end
            dmem_ack = 1'b0;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_sw_same_cycle();
        test_lb_wait();
        test_lhu_lh();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        test_random();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
